// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit (MULT/MULTU/DIV/DIVU) that owns the HI/LO registers.
// A multiply takes 32 shift-add steps. A divide takes 32 restoring shift-subtract steps.
// Both work on operand magnitudes, and the signs are applied in the FIX state.
// Optional build macro MD_FAST_MUL_EN: multiplies use a combinational 32x32 product
// and go straight from IDLE to FIX. Divides are not affected by this macro.
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        md_op,
    input  logic [DATA_W-1:0] Read_data_1,
    input  logic [DATA_W-1:0] Read_data_2,
    input  logic              mthi,
    input  logic              mtlo,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t              state, state_nxt;
    logic [4:0]          count;
    logic                is_div, neg_q, neg_r, div_zero;
    logic [DATA_W-1:0]   step_operand, work_hi, work_lo;
    logic                issue, op_signed;
    logic [DATA_W-1:0]   abs_a, abs_b;
    logic [DATA_W:0]     mul_sum, div_shift;
    logic [DATA_W-1:0]   div_diff;
    logic                div_ok;

    // Magnitude of a possibly signed operand; the most negative value maps onto itself as unsigned.
    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                    input logic is_signed);
        if (is_signed && v < 0) return DATA_W'(-v);
        return v;
    endfunction

    // Conditional two's-complement negation for HI or LO.
    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    // Conditional two's-complement negation for the full {HI,LO} product.
    function automatic logic [2*DATA_W-1:0] cond_neg_wide(input logic [2*DATA_W-1:0] v,
                                                          input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    assign issue     = (state == IDLE) && start;
    assign op_signed = ~md_op[0];
    assign abs_a     = magnitude(Read_data_1, op_signed);
    assign abs_b     = magnitude(Read_data_2, op_signed);

`ifdef MD_FAST_MUL_EN
    logic [2*DATA_W-1:0] fast_prod;
    assign fast_prod = {{DATA_W{1'b0}}, abs_a} * {{DATA_W{1'b0}}, abs_b};
`endif

    // One multiply step adds the multiplicand when the multiplier LSB is set.
    // One divide step is a trial subtract of the divisor from the shifted partial remainder.
    assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, step_operand} : '0);
    assign div_shift = {work_hi, work_lo[DATA_W-1]};
    assign div_ok    = div_shift >= {1'b0, step_operand};
    assign div_diff  = div_shift[DATA_W-1:0] - step_operand;

    // Next-state logic; busy covers every non-IDLE state so the done cycle is free for a new issue.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        case (state)
            IDLE: if (start) begin
`ifdef MD_FAST_MUL_EN
                state_nxt = md_op[1] ? RUN : FIX;
`else
                state_nxt = RUN;
`endif
            end
            RUN:  if (count == 5'd31) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control, result flags and architectural HI/LO. Reset aborts any operation in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            done     <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == FIX);
            if (issue)
                count <= '0;
            else if (state == RUN)
                count <= count + 5'd1;
            if (issue) begin
                is_div   <= md_op[1];
                neg_q    <= op_signed & (Read_data_1[DATA_W-1] ^ Read_data_2[DATA_W-1]);
                neg_r    <= op_signed & Read_data_1[DATA_W-1];
                div_zero <= (Read_data_2 == '0);
            end
            if (state == FIX) begin
                if (!is_div) begin
                    {hi_out, lo_out} <= cond_neg_wide({work_hi, work_lo}, neg_q);
                end else if (div_zero) begin
                    // The remainder register still holds |rs|, so restoring the dividend sign gives rs.
                    hi_out <= cond_neg(work_hi, neg_r);
                    lo_out <= '1;
                end else begin
                    hi_out <= cond_neg(work_hi, neg_r);
                    lo_out <= cond_neg(work_lo, neg_q);
                end
            end else if (state == IDLE && !start) begin
                if (mthi) hi_out <= Read_data_1;
                if (mtlo) lo_out <= Read_data_1;
            end
        end
    end

    // Working datapath. The control state alone decides whether these contents mean anything.
    always_ff @(posedge clock) begin
        if (issue) begin
            if (md_op[1]) begin
                work_hi      <= '0;
                work_lo      <= abs_a;
                step_operand <= abs_b;
            end else begin
`ifdef MD_FAST_MUL_EN
                {work_hi, work_lo} <= fast_prod;
`else
                work_hi      <= '0;
                work_lo      <= abs_b;
                step_operand <= abs_a;
`endif
            end
        end else if (state == RUN) begin
            if (is_div) begin
                work_hi <= div_ok ? div_diff : div_shift[DATA_W-1:0];
                work_lo <= {work_lo[DATA_W-2:0], div_ok};
            end else begin
                work_hi <= mul_sum[DATA_W:1];
                work_lo <= {mul_sum[0], work_lo[DATA_W-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, hazards, mid-operation reset,
// back-to-back issue and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  md_op = 2'b00;
    logic [31:0] rs = '0, rt = '0;
    logic        mthi = 1'b0, mtlo = 1'b0;
    logic [31:0] hi_out, lo_out;
    logic        busy, done;
    int          errors = 0;
    int          checks = 0;

    muldiv_unit #(.DATA_W(32)) dut (
        .clock(clock), .reset(reset), .start(start), .md_op(md_op),
        .Read_data_1(rs), .Read_data_2(rt), .mthi(mthi), .mtlo(mtlo),
        .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Reference: {HI,LO} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, b);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'b00: return 64'(sa * sb);
            2'b01: return 64'(ua * ub);
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] op);
`ifdef MD_FAST_MUL_EN
        return op[1] ? 34 : 2;
`else
        return 34;
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issues one operation (caller sits at a negedge) and waits up to 60 cycles for done.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, b,
                          output logic [31:0] hi, lo, output int lat,
                          output int busy_bad, output bit stable);
        logic [31:0] hi0, lo0;
        hi0 = hi_out; lo0 = lo_out;
        lat = -1; busy_bad = 0; stable = 1'b1;
        md_op = op; rs = a; rt = b; start = 1'b1;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(negedge clock);
            if (k == 1) begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
                md_op = 2'($urandom); rs = $urandom; rt = $urandom;
            end
            if (done) begin
                lat = k;
                if (busy) busy_bad++;
            end else begin
                if (!busy) busy_bad++;
                if (hi_out !== hi0 || lo_out !== lo0) stable = 1'b0;
            end
        end
        hi = hi_out; lo = lo_out;
    endtask

    task automatic test_reset;
        @(negedge clock);
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (hi_out !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi_out); end
        checks++; if (lo_out !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo_out); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_directed;
        logic [1:0]  ops[9]  = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00};
        logic [31:0] as[9]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7, 32'd5,
                                 32'h8000_0000, 32'd9, 32'h8000_0000, 32'd6};
        logic [31:0] bs[9]   = '{32'd2, 32'd7, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0,
                                 32'h8000_0000, 32'hFFFF_FFFE};
        logic [31:0] ehi[9]  = '{32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd5, 32'd0, 32'd9,
                                 32'h4000_0000, 32'hFFFF_FFFF};
        logic [31:0] elo[9]  = '{32'hFFFF_FFFE, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'd3,
                                 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,
                                 32'hFFFF_FFF4};
        logic [31:0] hi, lo;
        int lat, bb;
        bit st;
        for (int i = 0; i < 9; i++) begin
            run_op(ops[i], as[i], bs[i], hi, lo, lat, bb, st);
            checks++; if (lat !== exp_lat(ops[i])) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, exp_lat(ops[i])); end
            checks++; if (hi !== ehi[i]) begin errors++; $display("FAIL dir%0d_hi: got %h want %h", i, hi, ehi[i]); end
            checks++; if (lo !== elo[i]) begin errors++; $display("FAIL dir%0d_lo: got %h want %h", i, lo, elo[i]); end
            checks++; if (bb !== 0) begin errors++; $display("FAIL dir%0d_busy: %0d bad cycles want 0", i, bb); end
            checks++; if (st !== 1'b1) begin errors++; $display("FAIL dir%0d_partial: HI/LO changed early got %b want 1", i, st); end
            @(negedge clock);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, done); end
        end
    endtask

    task automatic test_hazards;
        logic [31:0] hi0, lo0, dhi, dlo;
        logic [63:0] exp;
        int lat, extra;
        bit stable;
        hi0 = hi_out; lo0 = lo_out;
        exp = model(2'b11, 32'd1000, 32'd7);
        md_op = 2'b11; rs = 32'd1000; rt = 32'd7; start = 1'b1;
        lat = -1; extra = 0; stable = 1'b1; dhi = '0; dlo = '0;
        for (int k = 1; k <= 42; k++) begin
            @(negedge clock);
            if (done) begin
                if (lat < 0) begin lat = k; dhi = hi_out; dlo = lo_out; end
                else extra++;
            end
            if (k < 34 && (hi_out !== hi0 || lo_out !== lo0)) stable = 1'b0;
            if (k == 41) begin
                checks++; if (lo_out !== 32'h1234) begin errors++; $display("FAIL mtlo_write: got %h want 00001234", lo_out); end
                checks++; if (hi_out !== exp[63:32]) begin errors++; $display("FAIL mtlo_hi_kept: got %h want %h", hi_out, exp[63:32]); end
            end
            case (k)
                1:  start = 1'b0;
                10: begin start = 1'b1; md_op = 2'b00; rs = 32'd5; rt = 32'd5; mthi = 1'b1; end
                11: begin start = 1'b0; mthi = 1'b0; end
                40: begin mtlo = 1'b1; rs = 32'h1234; end
                41: mtlo = 1'b0;
                default: ;
            endcase
        end
        checks++; if (lat !== 34) begin errors++; $display("FAIL hazard_latency: got %0d want 34", lat); end
        checks++; if (extra !== 0) begin errors++; $display("FAIL hazard_queued: %0d extra done pulses want 0", extra); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL hazard_mthi_busy: HI/LO changed early got %b want 1", stable); end
        checks++; if ({dhi, dlo} !== exp) begin errors++; $display("FAIL hazard_result: got %h want %h", {dhi, dlo}, exp); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] hi, lo;
        logic [63:0] exp;
        int lat, bb, dones;
        bit st;
        md_op = 2'b10; rs = 32'hFFFF_FF9C; rt = 32'd3; start = 1'b1;
        for (int k = 1; k < 15; k++) begin
            @(negedge clock);
            if (k == 1) start = 1'b0;
        end
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
        checks++; if (hi_out !== 32'h0) begin errors++; $display("FAIL midreset_hi: got %h want 0", hi_out); end
        checks++; if (lo_out !== 32'h0) begin errors++; $display("FAIL midreset_lo: got %h want 0", lo_out); end
        @(negedge clock);
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (done) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL midreset_done: %0d pulses want 0", dones); end
        exp = model(2'b01, 32'd12345, 32'd6789);
        run_op(2'b01, 32'd12345, 32'd6789, hi, lo, lat, bb, st);
        checks++; if (lat !== exp_lat(2'b01)) begin errors++; $display("FAIL postreset_latency: got %0d want %0d", lat, exp_lat(2'b01)); end
        checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL postreset_result: got %h want %h", {hi, lo}, exp); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] hi, lo;
        logic [63:0] exp;
        int lat, bb;
        bit st;
        run_op(2'b00, 32'hFFFF_0000, 32'h0001_0001, hi, lo, lat, bb, st);
        exp = model(2'b00, 32'hFFFF_0000, 32'h0001_0001);
        checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL b2b_first: got %h want %h", {hi, lo}, exp); end
        // Issue in the done cycle with MTHI asserted at the same time: the start must win.
        mthi = 1'b1;
        run_op(2'b10, 32'd100, 32'hFFFF_FFF9, hi, lo, lat, bb, st);
        exp = model(2'b10, 32'd100, 32'hFFFF_FFF9);
        checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency: got %0d want 34", lat); end
        checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL b2b_second: got %h want %h", {hi, lo}, exp); end
    endtask

    task automatic test_random;
        logic [31:0] a, b, hi, lo;
        logic [1:0]  op;
        logic [63:0] exp;
        int lat, bb;
        bit st;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a = pick();
            b = pick();
            exp = model(op, a, b);
            run_op(op, a, b, hi, lo, lat, bb, st);
            checks++; if ({hi, lo} !== exp || lat !== exp_lat(op) || bb !== 0)
                begin errors++; $display("FAIL rand%0d op=%0d a=%h b=%h: got %h lat %0d busybad %0d want %h lat %0d", i, op, a, b, {hi, lo}, lat, bb, exp, exp_lat(op)); end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_hazards;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
